// File: rtl/tdes_pkg.sv
`default_nettype none
// ============================================================================
// tdes_pkg : shared types and constants for the 3DES pass sequencer
// Rev 1.0
// ============================================================================
package tdes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef logic [1:0] pass_t;

  localparam pass_t LAST_PASS = 2'd2;

  localparam logic KEY_SEL_K1 = 1'b0;
  localparam logic KEY_SEL_K2 = 1'b1;

  // Bit p holds the core direction for pass p (1 = decrypt).
  localparam logic [2:0] ENC_DIR = 3'b010;
  localparam logic [2:0] DEC_DIR = 3'b101;

  function automatic logic key_sel(input pass_t p);
    return (p == 2'd1) ? KEY_SEL_K2 : KEY_SEL_K1;
  endfunction

  function automatic logic pass_dir(input logic dec, input pass_t p);
    return dec ? DEC_DIR[p] : ENC_DIR[p];
  endfunction

endpackage
`default_nettype wire

// File: rtl/tdes_timeout_counter.sv
`default_nettype none
// ============================================================================
// tdes_timeout_counter : per-pass watchdog, flags the TIMEOUT-th counted cycle
// Rev 1.0
// ============================================================================
module tdes_timeout_counter #(
  parameter int TIMEOUT = 32,
  parameter int TW      = 6
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear_i,
  input  logic count_en_i,
  output logic rollover_o
);

  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  // Saturates at LAST so a stalled enable cannot wrap back to zero.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_en_i && (count_q != LAST)) begin
      count_d = count_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign rollover_o = count_en_i && (count_q == LAST);

endmodule
`default_nettype wire

// File: rtl/tdes_pass_sequencer.sv
`default_nettype none
// ============================================================================
// tdes_pass_sequencer : time-shares one DES core across the three EDE passes
// Rev 1.0
// ============================================================================
module tdes_pass_sequencer
  import tdes_pkg::*;
#(
  parameter int TIMEOUT = 32,
  parameter int TW      = 6
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        abort,
  input  logic        blk_valid,
  output logic        blk_ready,
  input  logic [63:0] blk_in,
  input  logic        mode_decrypt,
  input  logic [63:0] key1,
  input  logic [63:0] key2,
  output logic        core_start,
  output logic        core_decrypt,
  output logic [63:0] core_key,
  output logic [63:0] core_din,
  input  logic [63:0] core_dout,
  input  logic        core_done,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_out,
  output logic        busy,
  output logic [1:0]  pass_idx,
  output logic        err
);

  state_t      state_q, state_d;
  pass_t       pass_q, pass_d;
  logic [63:0] work_q, work_d;
  logic [63:0] k1_q, k1_d;
  logic [63:0] k2_q, k2_d;
  logic [63:0] key_q, key_d;
  logic        mode_q, mode_d;
  logic        dir_q, dir_d;

  pass_t       w_next_pass;
  logic        w_roll;
  logic        w_err;

  function automatic logic [63:0] pass_key(input pass_t p, input logic [63:0] ka,
                                           input logic [63:0] kb);
    return (key_sel(p) == KEY_SEL_K2) ? kb : ka;
  endfunction

  tdes_timeout_counter #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_wdog (
    .clk        (clk),
    .n_rst      (n_rst),
    .clear_i    (state_q == ST_START),
    .count_en_i (state_q == ST_WAIT),
    .rollover_o (w_roll)
  );

  assign w_next_pass = pass_q + 2'd1;

  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    work_d  = work_q;
    k1_d    = k1_q;
    k2_d    = k2_q;
    key_d   = key_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    w_err   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (blk_valid && !abort) begin
          work_d  = blk_in;
          k1_d    = key1;
          k2_d    = key2;
          mode_d  = mode_decrypt;
          pass_d  = 2'd0;
          key_d   = pass_key(2'd0, key1, key2);
          dir_d   = pass_dir(mode_decrypt, 2'd0);
          state_d = ST_START;
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        // A done arriving on the timeout cycle still counts as success.
        if (core_done) begin
          work_d = core_dout;
          if (pass_q != LAST_PASS) begin
            pass_d  = w_next_pass;
            key_d   = pass_key(w_next_pass, k1_q, k2_q);
            dir_d   = pass_dir(mode_q, w_next_pass);
            state_d = ST_START;
          end else begin
            state_d = ST_DONE;
          end
        end else if (w_roll) begin
          w_err   = 1'b1;
          pass_d  = 2'd0;
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          pass_d  = 2'd0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d = ST_IDLE;
      pass_d  = 2'd0;
      work_d  = work_q;
      w_err   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      pass_q  <= 2'd0;
      work_q  <= '0;
      k1_q    <= '0;
      k2_q    <= '0;
      key_q   <= '0;
      mode_q  <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      work_q  <= work_d;
      k1_q    <= k1_d;
      k2_q    <= k2_d;
      key_q   <= key_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
    end
  end

  assign blk_ready    = (state_q == ST_IDLE) && !abort;
  assign core_start   = (state_q == ST_START);
  assign core_decrypt = dir_q;
  assign core_key     = key_q;
  assign core_din     = work_q;
  assign res_valid    = (state_q == ST_DONE);
  assign res_out      = work_q;
  assign busy         = (state_q != ST_IDLE);
  assign pass_idx     = pass_q;
  assign err          = w_err;

endmodule
`default_nettype wire

// File: tb/tb_tdes_pass_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_tdes_pass_sequencer : directed bench with an additive stand-in core (L=4)
// Rev 1.0
// ============================================================================
module tb_tdes_pass_sequencer;

  localparam int TIMEOUT = 32;
  localparam int TW      = 6;
  localparam int L       = 4;

  localparam logic [63:0] K1   = 64'h3b38_9837_1520_f75e;
  localparam logic [63:0] K2   = 64'h8c1f_609e_fca3_2a78;
  localparam logic [63:0] PT   = 64'h1234_5678_90ab_cdef;
  // Stand-in core: E(k,x) = x + k, D(k,x) = x - k, so EDE gives x + 2*K1 - K2.
  localparam logic [63:0] GOLD = PT + K1 + K1 - K2;

  logic        clk = 1'b0;
  logic        n_rst, abort, blk_valid, blk_ready, mode_decrypt;
  logic [63:0] blk_in, key1, key2;
  logic        core_start, core_decrypt, core_done;
  logic [63:0] core_key, core_din, core_dout;
  logic        res_valid, res_ready, busy, err;
  logic [63:0] res_out;
  logic [1:0]  pass_idx;

  int n_checks = 0;
  int n_errors = 0;

  tdes_pass_sequencer #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk(clk), .n_rst(n_rst), .abort(abort),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_in(blk_in),
    .mode_decrypt(mode_decrypt), .key1(key1), .key2(key2),
    .core_start(core_start), .core_decrypt(core_decrypt), .core_key(core_key),
    .core_din(core_din), .core_dout(core_dout), .core_done(core_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_out(res_out),
    .busy(busy), .pass_idx(pass_idx), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural core: done arrives L cycles after the start cycle; logs every launch.
  logic [63:0] log_key [64];
  logic [63:0] log_din [64];
  logic        log_dir [64];
  int          log_n;
  int          hang_at;
  logic        m_run, m_drop;
  int          m_cnt;
  logic [63:0] m_res;
  int          err_cnt;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_run <= 1'b0; m_drop <= 1'b0; m_cnt <= 0; m_res <= '0;
      core_done <= 1'b0; core_dout <= '0; log_n <= 0;
    end else begin
      core_done <= 1'b0;
      if (core_start) begin
        m_run  <= 1'b1;
        m_cnt  <= 1;
        m_drop <= (log_n == hang_at);
        m_res  <= core_decrypt ? (core_din - core_key) : (core_din + core_key);
        if (log_n < 64) begin
          log_key[log_n] <= core_key;
          log_din[log_n] <= core_din;
          log_dir[log_n] <= core_decrypt;
        end
        log_n <= log_n + 1;
      end else if (m_run) begin
        if (m_cnt == L - 1) begin
          m_run     <= 1'b0;
          core_done <= !m_drop;
          core_dout <= m_res;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end
  end

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) err_cnt <= 0;
    else if (err) err_cnt <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_blk_ready"}, blk_ready, 1);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_pass_idx"}, pass_idx, 0);
    check({pfx, "_core_start"}, core_start, 0);
    check({pfx, "_core_decrypt"}, core_decrypt, 0);
    check({pfx, "_core_key"}, core_key, 0);
    check({pfx, "_core_din"}, core_din, 0);
    check({pfx, "_res_valid"}, res_valid, 0);
    check({pfx, "_res_out"}, res_out, 0);
    check({pfx, "_err"}, err, 0);
  endtask

  task automatic send_block(input logic [63:0] data, input logic dec);
    int n;
    n = 0;
    @(negedge clk);
    blk_in = data; mode_decrypt = dec; blk_valid = 1'b1;
    while (!blk_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_bound", 64'(n < 50), 1);
    @(posedge clk);
    #1 blk_valid = 1'b0;
  endtask

  int st_cyc [3];
  int st_pass[3];

  // Counts cycles from the acceptance edge; returns the first res_valid cycle.
  task automatic wait_result(output int lat);
    int ns;
    ns  = 0;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (core_start && ns < 3) begin
        st_cyc[ns] = k; st_pass[ns] = int'(pass_idx); ns++;
      end
      if (res_valid) begin
        lat = k;
        break;
      end
    end
    check("result_bound", 64'(lat > 0), 1);
  endtask

  task automatic take_result();
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
  endtask

  task automatic check_passes(input string pfx, input int base, input logic [2:0] dirs);
    check({pfx, "_key0"}, log_key[base],     K1);
    check({pfx, "_key1"}, log_key[base + 1], K2);
    check({pfx, "_key2"}, log_key[base + 2], K1);
    check({pfx, "_dir0"}, log_dir[base],     dirs[0]);
    check({pfx, "_dir1"}, log_dir[base + 1], dirs[1]);
    check({pfx, "_dir2"}, log_dir[base + 2], dirs[2]);
  endtask

  initial begin
    int lat, base, bad, e0, t;
    logic found;
    n_rst = 1'b0; abort = 1'b0; blk_valid = 1'b0; blk_in = '0; mode_decrypt = 1'b0;
    key1 = K1; key2 = K2; res_ready = 1'b0; hang_at = -1;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    n_rst = 1'b1;

    // Encrypt
    base = 0;
    send_block(PT, 1'b0);
    wait_result(lat);
    check("enc_latency", 64'(lat), 16);
    check("enc_start0", 64'(st_cyc[0]), 1);
    check("enc_start1", 64'(st_cyc[1]), 6);
    check("enc_start2", 64'(st_cyc[2]), 11);
    check("enc_pass1", 64'(st_pass[1]), 1);
    check("enc_pass2", 64'(st_pass[2]), 2);
    check("enc_din0", log_din[base], PT);
    check_passes("enc", base, 3'b010);
    check("enc_result", res_out, GOLD);
    take_result();
    @(negedge clk);
    check("enc_idle", busy, 0);

    // Round trip
    base = log_n;
    send_block(GOLD, 1'b1);
    wait_result(lat);
    check_passes("dec", base, 3'b101);
    check("dec_result", res_out, PT);
    take_result();

    // Backpressure, with a second block offered while DONE
    base = log_n;
    send_block(PT, 1'b0);
    wait_result(lat);
    blk_in = GOLD; mode_decrypt = 1'b1; blk_valid = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (res_out !== GOLD || blk_ready !== 1'b0 || res_valid !== 1'b1) bad++;
    end
    check("bp_stable", 64'(bad), 0);
    check("bp_no_extra_launch", 64'(log_n - base), 3);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("bp_idle_busy", busy, 0);
    check("bp_idle_ready", blk_ready, 1);
    @(posedge clk);
    #1 blk_valid = 1'b0;
    wait_result(lat);
    check("bp2_latency", 64'(lat), 16);
    check("bp2_result", res_out, PT);
    take_result();

    // Abort coinciding with pass-1 done
    e0 = err_cnt;
    send_block(PT, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (core_done && pass_idx == 2'd1) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_found_done", found, 1);
    abort = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_pass_idx", pass_idx, 0);
    check("abort_blk_ready", blk_ready, 0);
    abort = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("abort_quiet", 64'(bad), 0);
    check("abort_no_err", 64'(err_cnt - e0), 0);
    send_block(PT, 1'b0);
    wait_result(lat);
    check("abort_next_result", res_out, GOLD);
    take_result();

    // Hung core on pass 2
    e0 = err_cnt;
    hang_at = log_n + 2;
    send_block(PT, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (core_start && pass_idx == 2'd2) begin
        found = 1'b1;
        break;
      end
    end
    check("hang_found_start", found, 1);
    t = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (err) begin
        t = k;
        break;
      end
    end
    check("hang_err_delay", 64'(t), TIMEOUT);
    @(negedge clk);
    check("hang_idle", busy, 0);
    check("hang_err_once", 64'(err_cnt - e0), 1);
    hang_at = -1;

    // Reset mid-block during pass 0
    send_block(PT, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("mid_busy_before", busy, 1);
    #2 n_rst = 1'b0;
    #1 check_reset_outputs("async");
    @(negedge clk);
    n_rst = 1'b1;
    send_block(PT, 1'b0);
    wait_result(lat);
    check("post_reset_result", res_out, GOLD);
    take_result();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
